alu_ejecucion: RTL



---
 rtl/alu_ejecucion.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_ejecucion.sv
// Execute/write-back stage for a small register file: single-cycle ALU ops,
// a 4-cycle shift-add multiply, and forwarding of its own pending write-back.
module alu_ejecucion #(
    parameter int W  = 4,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [AW-1:0] rs_a,
    input  logic [AW-1:0] rt_a,
    input  logic [AW-1:0] rd_a,
    output logic [AW-1:0] rs,
    output logic [AW-1:0] rt,
    input  logic [W-1:0]  crs,
    input  logic [W-1:0]  crt,
    output logic [W-1:0]  dw,
    output logic [AW-1:0] rw,
    output logic          rwe,
    output logic          zero,
    output logic          carry
);
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_MUL = 3'b110,
        OP_NOP = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_WB
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    dw_q, dw_d;
    logic [AW-1:0]   rw_q, rw_d;
    logic            rwe_q, rwe_d;
    logic            zero_q, zero_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;

    op_e             op_i;
    logic            accept;
    logic [W-1:0]    op_a, op_b;
    logic [W:0]      sum_ext, dif_ext;
    logic [W-1:0]    alu_res;
    logic            alu_carry;
    logic [2*W-1:0]  partial, acc_sum;

    assign rs       = rs_a;
    assign rt       = rt_a;
    assign in_ready = (state_q != ST_MUL);
    assign accept   = in_valid && in_ready;
    assign op_i     = op_e'(op);

    // The register file commits dw on the same edge we capture, so bypass it.
    assign op_a = (rwe_q && (rw_q == rs_a)) ? dw_q : crs;
    assign op_b = (rwe_q && (rw_q == rt_a)) ? dw_q : crt;

    assign sum_ext = {1'b0, op_a} + {1'b0, op_b};
    assign dif_ext = {1'b0, op_a} - {1'b0, op_b};

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_i)
            OP_ADD: begin
                alu_res   = sum_ext[W-1:0];
                alu_carry = sum_ext[W];
            end
            OP_SUB: begin
                alu_res   = dif_ext[W-1:0];
                alu_carry = dif_ext[W];
            end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLT:  alu_res = {{(W-1){1'b0}}, (op_a < op_b)};
            default: alu_res = '0;
        endcase
    end

    assign partial = b_q[cnt_q] ? ({{W{1'b0}}, a_q} << cnt_q) : '0;
    assign acc_sum = acc_q + partial;

    always_comb begin
        state_d = state_q;
        dw_d    = dw_q;
        rw_d    = rw_q;
        rwe_d   = 1'b0;
        zero_d  = zero_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;

        case (state_q)
            ST_MUL: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = ST_WB;
                    dw_d    = acc_sum[W-1:0];
                    rw_d    = rw_q;
                    rwe_d   = 1'b1;
                    zero_d  = (acc_sum[W-1:0] == '0);
                    carry_d = |acc_sum[2*W-1:W];
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (op_i == OP_MUL) begin
                        state_d = ST_MUL;
                        a_d     = op_a;
                        b_d     = op_b;
                        cnt_d   = '0;
                        acc_d   = '0;
                        rw_d    = rd_a;
                    end else if (op_i != OP_NOP) begin
                        state_d = ST_WB;
                        dw_d    = alu_res;
                        rw_d    = rd_a;
                        rwe_d   = 1'b1;
                        zero_d  = (alu_res == '0);
                        carry_d = alu_carry;
                    end
                end
            end
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dw_q    <= '0;
            rw_q    <= '0;
            rwe_q   <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            dw_q    <= dw_d;
            rw_q    <= rw_d;
            rwe_q   <= rwe_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign dw    = dw_q;
    assign rw    = rw_q;
    assign rwe   = rwe_q;
    assign zero  = zero_q;
    assign carry = carry_q;
endmodule
